// File: rtl/alsu_cmd_driver_if.sv
// Command/response handshake bundle between a sequencer (master) and alsu_cmd_driver (slave).
// A transfer on either channel happens on a rising clk edge where valid and ready are both 1.
interface alsu_cmd_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_A;
    logic [2:0] cmd_B;
    logic [2:0] cmd_opcode;
    logic [6:0] cmd_flags;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_data;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_A, cmd_B, cmd_opcode, cmd_flags, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_A, cmd_B, cmd_opcode, cmd_flags, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alsu_cmd_driver.sv
// Initiator for the ALSU pin interface: drives one command, waits out latency/lockout, returns the result.
// Optional response statistics counters are built when ALSU_DRV_STATS_EN is defined.
module alsu_cmd_driver #(
    parameter int LATENCY        = 2,
    parameter int RECOVER_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    alsu_cmd_driver_if.slave bus,
    output logic [2:0]  A,
    output logic [2:0]  B,
    output logic [2:0]  opcode,
    output logic        cin,
    output logic        serial_in,
    output logic        direction,
    output logic        red_op_A,
    output logic        red_op_B,
    output logic        bypass_A,
    output logic        bypass_B,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds,
`ifdef ALSU_DRV_STATS_EN
    output logic [15:0] stat_ops,
    output logic [15:0] stat_errs,
`endif
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        CAPTURE = 3'd2,
        RECOVER = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pred_err;
    logic             led_seen;
    logic             cmd_fire;
    logic             rsp_fire;
    logic             cmd_bad;
    logic             leds_any;

    assign cmd_fire  = bus.cmd_valid & bus.cmd_ready;
    assign rsp_fire  = bus.rsp_valid & bus.rsp_ready;
    assign leds_any  = |alsu_leds;
    assign state_dbg = state;

    // Opcodes 110/111 are illegal, and reduction is only legal for AND/XOR.
    assign cmd_bad = (bus.cmd_opcode == 3'b110) || (bus.cmd_opcode == 3'b111) ||
                     ((bus.cmd_flags[3] || bus.cmd_flags[2]) && (bus.cmd_opcode > 3'b001));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            pred_err      <= 1'b0;
            led_seen      <= 1'b0;
            A             <= '0;
            B             <= '0;
            opcode        <= '0;
            cin           <= 1'b0;
            serial_in     <= 1'b0;
            direction     <= 1'b0;
            red_op_A      <= 1'b0;
            red_op_B      <= 1'b0;
            bypass_A      <= 1'b0;
            bypass_B      <= 1'b0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        A             <= bus.cmd_A;
                        B             <= bus.cmd_B;
                        opcode        <= bus.cmd_opcode;
                        {cin, serial_in, direction, red_op_A,
                         red_op_B, bypass_A, bypass_B} <= bus.cmd_flags;
                        pred_err      <= cmd_bad;
                        led_seen      <= 1'b0;
                        cnt           <= '0;
                        bus.cmd_ready <= 1'b0;
                        state         <= DRIVE;
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                DRIVE: begin
                    cnt      <= cnt + 1'b1;
                    led_seen <= led_seen | leds_any;
                    if (cnt == CNT_W'(LATENCY - 1))
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    bus.rsp_data <= alsu_out;
                    bus.rsp_err  <= pred_err | led_seen | leds_any;
                    if (pred_err) begin
                        cnt   <= '0;
                        state <= RECOVER;
                    end else begin
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RECOVER: begin
                    // The ALSU ignores its pins during the LED lockout; keep them held until it ends.
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(RECOVER_CYCLES - 1)) begin
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.cmd_ready <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

`ifdef ALSU_DRV_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (rsp_fire) begin
            if (stat_ops != 16'hFFFF)
                stat_ops <= stat_ops + 1'b1;
            if (bus.rsp_err && (stat_errs != 16'hFFFF))
                stat_errs <= stat_errs + 1'b1;
        end
    end
`else
    logic unused_rsp_fire;
    assign unused_rsp_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Directed bench for alsu_cmd_driver with a small two-stage ALSU model and a response scoreboard.
module tb_alsu_cmd_driver;

    logic        clk;
    logic        rst;
    logic [2:0]  A, B, opcode;
    logic        cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;
    logic [2:0]  state_dbg;
`ifdef ALSU_DRV_STATS_EN
    logic [15:0] stat_ops, stat_errs;
`endif

    alsu_cmd_driver_if bus ();

    alsu_cmd_driver dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .cin       (cin),
        .serial_in (serial_in),
        .direction (direction),
        .red_op_A  (red_op_A),
        .red_op_B  (red_op_B),
        .bypass_A  (bypass_A),
        .bypass_B  (bypass_B),
        .alsu_out  (alsu_out),
        .alsu_leds (alsu_leds),
`ifdef ALSU_DRV_STATS_EN
        .stat_ops  (stat_ops),
        .stat_errs (stat_errs),
`endif
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    int cyc;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- ALSU model ----------------
    logic [6:0] pin_f;
    assign pin_f = {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B};

    function automatic logic alsu_invalid(input logic [2:0] op, input logic [6:0] f);
        return (op == 3'b110) || (op == 3'b111) || ((f[3] || f[2]) && (op > 3'b001));
    endfunction

    function automatic logic [5:0] alsu_calc(input logic [2:0] op, input logic [2:0] a,
                                             input logic [2:0] b, input logic [6:0] f);
        logic [5:0] r;
        r = '0;
        if (f[1])      r = {3'b0, a};
        else if (f[0]) r = {3'b0, b};
        else begin
            case (op)
                3'd0: r = f[3] ? {5'b0, &a} : (f[2] ? {5'b0, &b} : {3'b0, a & b});
                3'd1: r = f[3] ? {5'b0, ^a} : (f[2] ? {5'b0, ^b} : {3'b0, a ^ b});
                3'd2: r = 6'(a) + 6'(b) + 6'(f[6]);
                3'd3: r = 6'(a) * 6'(b);
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    logic [2:0] s1_a, s1_b, s1_op;
    logic [6:0] s1_f;
    logic       s1_chg;
    logic [3:0] lock;
    logic [5:0] m_out;
    logic       led_force;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_a <= '0; s1_b <= '0; s1_op <= '0; s1_f <= '0; s1_chg <= 1'b0;
            lock <= '0; m_out <= '0;
        end else begin
            s1_a   <= A;
            s1_b   <= B;
            s1_op  <= opcode;
            s1_f   <= pin_f;
            s1_chg <= ({A, B, opcode, pin_f} != {s1_a, s1_b, s1_op, s1_f});
            if (!alsu_invalid(s1_op, s1_f))
                m_out <= alsu_calc(s1_op, s1_a, s1_b, s1_f);
            if (alsu_invalid(s1_op, s1_f) && s1_chg) lock <= 4'd8;
            else if (lock != 0)                     lock <= lock - 1'b1;
        end
    end

    assign alsu_out  = m_out;
    assign alsu_leds = (lock != 0) ? 16'hFFFF : {15'b0, led_force};

    // ---------------- scoreboard ----------------
    logic [6:0] exp_q[$];
    int         lat_q[$];
    int         n_checks;
    int         n_fail;
    int         n_rsp;
    int         n_err_rsp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                            input logic [6:0] f, input logic [5:0] exp_data,
                            input logic exp_err, input int lat);
        int t;
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_A      = a;
        bus.cmd_B      = b;
        bus.cmd_flags  = f;
        t = 0;
        while (bus.cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cmd_accept", {31'b0, bus.cmd_ready}, 32'd1);
        exp_q.push_back({exp_err, exp_data});
        lat_q.push_back(cyc + lat);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("pins_driven", {23'b0, A, B, opcode, pin_f}, {23'b0, a, b, op, f});
        check("state_drive", {29'b0, state_dbg}, 32'd1);
    endtask

    task automatic get_rsp(input int stall);
        int         t;
        int         l;
        logic [6:0] e;
        t = 0;
        while (bus.rsp_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rsp_seen", {31'b0, bus.rsp_valid}, 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 7'h7F;
        l = (lat_q.size() != 0) ? lat_q.pop_front() : -1;
        check("rsp_data", {26'b0, bus.rsp_data}, {26'b0, e[5:0]});
        check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e[6]});
        check("rsp_latency", cyc, l);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, bus.rsp_valid}, 32'd1);
            check("stall_data", {25'b0, bus.rsp_err, bus.rsp_data}, {25'b0, e});
            check("stall_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        n_rsp++;
        if (e[6]) n_err_rsp++;
        check("rsp_retired", {31'b0, bus.rsp_valid}, 32'd0);
        check("ready_after_rsp", {31'b0, bus.cmd_ready}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        cyc = 0; n_checks = 0; n_fail = 0; n_rsp = 0; n_err_rsp = 0;
        led_force = 1'b0;
        rst = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_A = '0; bus.cmd_B = '0;
        bus.cmd_opcode = '0; bus.cmd_flags = '0; bus.rsp_ready = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.cmd_valid  = 1'($urandom_range(0, 1));
            bus.cmd_A      = 3'($urandom_range(0, 7));
            bus.cmd_B      = 3'($urandom_range(0, 7));
            bus.cmd_opcode = 3'($urandom_range(0, 7));
            bus.cmd_flags  = 7'($urandom_range(0, 127));
            bus.rsp_ready  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
        check("rst_rsp", {24'b0, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 32'd0);
        check("rst_pins", {16'b0, A, B, opcode, pin_f}, 32'd0);
        check("rst_state", {29'b0, state_dbg}, 32'd0);
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        rst = 1'b1;
        #1 check("release_cmd_ready_low", {31'b0, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        check("release_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);

        // ADD 3+4+cin
        send_cmd(3'b010, 3'd3, 3'd4, 7'b1000000, 6'd8, 1'b0, 4);
        get_rsp(0);

        // Invalid opcode: lockout, out unchanged from previous op
        send_cmd(3'b110, 3'd7, 3'd0, 7'b0, 6'd8, 1'b1, 20);
        get_rsp(0);

        // MULT after recovery
        send_cmd(3'b011, 3'd3, 3'd5, 7'b0, 6'd15, 1'b0, 4);
        get_rsp(0);

        // Reduction with ADD is invalid
        send_cmd(3'b010, 3'd1, 3'd1, 7'b0001000, 6'd15, 1'b1, 20);
        get_rsp(0);

        // Reduction AND of A=7
        send_cmd(3'b000, 3'd7, 3'd2, 7'b0001000, 6'd1, 1'b0, 4);
        get_rsp(0);

        // Backpressure with a new command presented while busy
        send_cmd(3'b001, 3'd6, 3'd3, 7'b0, 6'd5, 1'b0, 4);
        bus.cmd_valid = 1'b1; bus.cmd_opcode = 3'b011; bus.cmd_A = 3'd2;
        bus.cmd_B = 3'd2; bus.cmd_flags = 7'b0;
        get_rsp(10);
        exp_q.push_back({1'b0, 6'd4});
        lat_q.push_back(cyc + 4);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("busy_cmd_pins", {23'b0, A, B, opcode, pin_f}, {23'b0, 3'd2, 3'd2, 3'b011, 7'b0});
        get_rsp(0);

        // LEDs seen during DRIVE on an otherwise valid op
        send_cmd(3'b010, 3'd1, 3'd2, 7'b0, 6'd3, 1'b1, 4);
        led_force = 1'b1;
        @(negedge clk);
        led_force = 1'b0;
        get_rsp(0);

        // Reset during DRIVE discards the in-flight response
        send_cmd(3'b001, 3'd5, 3'd3, 7'b0, 6'd6, 1'b0, 4);
        rst = 1'b0;
        exp_q.delete();
        lat_q.delete();
        #1;
        check("midrst_outputs", {22'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_data, state_dbg},
              32'd0);
        check("midrst_pins", {16'b0, A, B, opcode, pin_f}, 32'd0);
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        bus.rsp_ready = 1'b0;
        send_cmd(3'b001, 3'd5, 3'd3, 7'b0, 6'd6, 1'b0, 4);
        get_rsp(0);

        // A few random valid operations
        for (int i = 0; i < 4; i++) begin
            logic [2:0] op, a, b;
            logic [6:0] f;
            op = 3'($urandom_range(0, 3));
            a  = 3'($urandom_range(0, 7));
            b  = 3'($urandom_range(0, 7));
            f  = {1'($urandom_range(0, 1)), 6'b0};
            send_cmd(op, a, b, f, alsu_calc(op, a, b, f), 1'b0, 4);
            get_rsp(0);
        end

`ifdef ALSU_DRV_STATS_EN
        check("stat_ops", {16'b0, stat_ops}, n_rsp);
        check("stat_errs", {16'b0, stat_errs}, n_err_rsp);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alsu_cmd_driver.md
Name: alsu_cmd_driver

Overview:
- Initiator side of the ALSU pin interface.
- Accepts one operation command at a time over a valid/ready handshake and drives the ALSU input pins, holding them stable for the ALSU's two-register latency.
- Samples the ALSU result, flags invalid operations and waits out the ALSU LED-blink lockout, then returns a response over a second valid/ready handshake.
- Sits between a test/control sequencer and the ALSU.

Parameters:
- LATENCY, 2: clock edges from pin change to valid ALSU `out`.
- RECOVER_CYCLES, 16: cycles the ALSU ignores inputs after an invalid op.
- CNT_W, 5: width of the internal wait counter; must hold max(LATENCY, RECOVER_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command.
- cmd_A, cmd_B, cmd_opcode  in  3 each  operands and opcode.
- cmd_flags  in  7  {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}.
- A, B, opcode  out  3 each  to ALSU pins.
- cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B  out  1 each  to ALSU pins.
- alsu_out  in  6  ALSU `out`.
- alsu_leds  in  16  ALSU `leds`.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  6  captured ALSU result.
- rsp_err  out  1  operation invalid or LEDs observed active.

Behaviour:
- Reset (rst=0, async): state=IDLE, all ALSU pin outputs 0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, counter=0.
- cmd_ready=1 only in IDLE.
- IDLE:
  - On cmd_valid&cmd_ready, register all command fields onto the pin outputs and compute pred_err.
  - pred_err = (opcode==3'b110 || opcode==3'b111 || ((red_op_A||red_op_B) && opcode>3'b001)).
  - Clear led_seen; counter=0; go to DRIVE.
- DRIVE:
  - Pins held constant. `direction` is used unregistered inside the ALSU, so it too stays stable for the whole operation, through RECOVER.
  - counter increments each cycle; led_seen |= |alsu_leds.
  - When counter==LATENCY-1, go to CAPTURE. The first DRIVE cycle is the first edge after the pins change.
- CAPTURE (one cycle):
  - rsp_data <= alsu_out; rsp_err <= pred_err | led_seen | (|alsu_leds).
  - If pred_err, counter=0 and go to RECOVER; else go to RESP.
- RECOVER:
  - Count RECOVER_CYCLES cycles, pins still held, then go to RESP.
  - rsp_data is still the value captured in CAPTURE; the ALSU does not update `out` on an invalid op.
- RESP:
  - rsp_valid=1; rsp_data/rsp_err stable until rsp_ready.
  - On rsp_valid&rsp_ready, rsp_valid<=0 and go to IDLE. The next command can be accepted in the following cycle.
- Pins keep their last values in IDLE; they are never returned to 0 between commands.
- Command-to-response latency is LATENCY+2 cycles for a valid op, LATENCY+2+RECOVER_CYCLES for an invalid op, plus any rsp_ready stall.
- cmd_valid while busy: not accepted, no effect. cmd_valid and rsp_ready in the same cycle: response retires first; the command is accepted only once back in IDLE.
- rst asserted mid-operation: immediate return to reset values, any in-flight response discarded.
- No arithmetic is performed; all widths pass through unchanged.

Optional Feature:
- Macro ALSU_DRV_STATS_EN.
- When defined:
  - Extra outputs stat_ops[15:0] and stat_errs[15:0], reset to 0.
  - stat_ops increments on each rsp handshake; stat_errs increments when that response has rsp_err=1.
  - Both saturate at 16'hFFFF.
- When undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, cmd_ready=0. Release -> cmd_ready=1 next cycle.
- ADD with A=3, B=4, cin=1 -> rsp_valid 4 cycles after handshake, rsp_data=6'd8, rsp_err=0.
- opcode=3'b110, A=7 -> rsp_err=1 after LATENCY+2+16 cycles; next command MULT A=3, B=5 -> rsp_data=6'd15, rsp_err=0.
- red_op_A=1 with opcode=ADD -> rsp_err=1. red_op_A=1 with opcode=AND, A=7 -> rsp_data=1, rsp_err=0.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_data, rsp_err stable, cmd_ready=0; handshake then cmd_ready=1.
- Reset mid-op: rst=0 during DRIVE of XOR A=5, B=3 -> no response emitted; after release a new XOR A=5, B=3 returns rsp_data=6'd6.
